// File: rtl/pq_save_buffer.sv
// Save-state write buffer.
// Converts level-held P/Q enables into single pushes into two small first-word-fall-through FIFOs.
module pq_save_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              valid_o,
  output logic [ADDR_W:0]   count_o,
  output logic              drop_o
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pop;
  logic              full;
  logic              accept;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == FULL_CNT);
  assign pop     = valid_o & ready_i;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign accept  = push_i & (~full | pop);
  assign drop_o  = push_i & full & ~pop;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (accept && !pop)      count_d = count_q + (ADDR_W + 1)'(1);
    else if (!accept && pop) count_d = count_q - (ADDR_W + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; reads are masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module pq_save_buffer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              writeRegP,
  input  logic              writeRegQ,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              clear_err,
  output logic [WIDTH-1:0]  p_data,
  output logic              p_valid,
  input  logic              p_ready,
  output logic [WIDTH-1:0]  q_data,
  output logic              q_valid,
  input  logic              q_ready,
  output logic [ADDR_W:0]   p_count,
  output logic [ADDR_W:0]   q_count,
  output logic              overflow,
  output logic              conflict
);
  // Handshake: a head word leaves its FIFO at a rising clock edge where valid and ready are both 1;
  // valid never depends on ready, and ready while empty is ignored.
  logic prev_p_q, prev_q_q;
  logic overflow_q, overflow_d;
  logic conflict_q, conflict_d;
  logic rise_p, rise_q;
  logic push_p, push_q;
  logic drop_p, drop_q;
  logic both_rise;

  assign rise_p    = writeRegP & ~prev_p_q;
  assign rise_q    = writeRegQ & ~prev_q_q;
  assign both_rise = rise_p & rise_q;
  // Simultaneous rises are ambiguous, so neither side is written.
  assign push_p    = rise_p & ~rise_q;
  assign push_q    = rise_q & ~rise_p;

  pq_save_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_p_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push_p),
    .data_i  (data_in),
    .ready_i (p_ready),
    .data_o  (p_data),
    .valid_o (p_valid),
    .count_o (p_count),
    .drop_o  (drop_p)
  );

  pq_save_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_q_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push_q),
    .data_i  (data_in),
    .ready_i (q_ready),
    .data_o  (q_data),
    .valid_o (q_valid),
    .count_o (q_count),
    .drop_o  (drop_q)
  );

  // New error events win over a clear in the same cycle.
  assign overflow_d = (overflow_q & ~clear_err) | drop_p | drop_q;
  assign conflict_d = (conflict_q & ~clear_err) | both_rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_p_q   <= 1'b0;
      prev_q_q   <= 1'b0;
      overflow_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      prev_p_q   <= writeRegP;
      prev_q_q   <= writeRegQ;
      overflow_q <= overflow_d;
      conflict_q <= conflict_d;
    end
  end

  assign overflow = overflow_q;
  assign conflict = conflict_q;
endmodule
